debounce_bank: RTL and testbench
================================

Name: debounce_bank

Overview:
- Multi-channel successor to the single-input debounce filter, for banks of push-buttons and switches.
- Each channel has its own input synchroniser, its own debounce counter, and registered rise/fall event pulses.
- Each channel also detects a long-press (hold) condition.
- Sits between board pins and the button/counter logic; every output is registered in the i_clk domain.

Parameters:
- NUM_CH, 4: number of independent channels (>=1).
- DEBOUNCE_LIMIT, 20: consecutive disagreeing cycles required to accept a new level (>=2).
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (>=2).
- HOLD_LIMIT, 1000: cycles o_debounced must stay high after o_rise before o_held pulses (>=2).

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_bouncy  in  NUM_CH  raw asynchronous inputs; bit n is channel n.
- o_debounced  out  NUM_CH  filtered stable level per channel.
- o_rise  out  NUM_CH  1-cycle pulse in the cycle o_debounced[n] first reads 1.
- o_fall  out  NUM_CH  1-cycle pulse in the cycle o_debounced[n] first reads 0.
- o_held  out  NUM_CH  1-cycle pulse when channel n has been high for HOLD_LIMIT-1 cycles after rising.

Behaviour:
- Interface: one clock (i_clk); reset i_rst is synchronous and active-high.
- Reset:
  - i_rst=1 at an edge clears all synchroniser flops, debounce counters, hold counters and state bits to 0.
  - Outputs read 0 after that edge. No pulse is generated by reset, even if o_debounced was 1.
- Channel independence: channels share nothing but clock and reset; activity on one never affects another.
- Synchroniser: s[n] is the last stage of a SYNC_STAGES-deep shift register fed by i_bouncy[n].
- Debounce counter, per channel, width $clog2(DEBOUNCE_LIMIT):
  - s==state: counter <= 0.
  - s!=state and counter < DEBOUNCE_LIMIT-1: counter <= counter+1.
  - s!=state and counter == DEBOUNCE_LIMIT-1: state <= s and counter <= 0 (accept).
  - Any single agreeing cycle restarts the count from 0, so glitches shorter than DEBOUNCE_LIMIT cycles are fully rejected.
- Latency: a clean level change on i_bouncy[n] reaches o_debounced[n] after exactly SYNC_STAGES+DEBOUNCE_LIMIT rising edges. The count starts with the first edge that samples the new level.
- o_debounced[n] = state[n] (a register, no combinational path from input).
- Edge pulses:
  - o_rise[n] is registered high at the same edge that state flips 0->1; o_fall[n] likewise for 1->0. Each is high for exactly one cycle.
  - Never both high on one channel in the same cycle.
  - Consecutive rise and fall on a channel are at least DEBOUNCE_LIMIT cycles apart.
- Hold counter, per channel, width $clog2(HOLD_LIMIT):
  - Cleared to 0 at the accept edge (state 0->1) and held at 0 while state=0.
  - While state=1 it increments each cycle, saturating at HOLD_LIMIT-1.
  - o_held[n] pulses for one cycle on the edge where the counter transitions to HOLD_LIMIT-1, i.e. HOLD_LIMIT-1 cycles after o_rise[n].
  - No repeat pulse until a fall and a new rise.
  - If the fall occurs first, the counter clears and there is no o_held.
- Reset mid-operation: partial debounce or hold counts are discarded. After reset releases, an input already high needs the full SYNC_STAGES+DEBOUNCE_LIMIT cycles to produce o_rise.
- i_bouncy is X-free in normal use; compare with != (not case inequality) so the block is synthesizable.

Test Plan (NUM_CH=4, DEBOUNCE_LIMIT=8, SYNC_STAGES=2, HOLD_LIMIT=32):
- Reset, then hold all inputs 0 for 50 cycles -> all outputs stay 0, no pulses.
- Step i_bouncy[0] 0->1 cleanly:
  - o_debounced[0] rises exactly 10 edges later, with o_rise[0] high for that single cycle.
  - o_held[0] pulses 31 cycles after o_rise[0], once only.
- Glitch i_bouncy[1] high for 7 cycles, low 1, high 7 -> o_debounced[1] never changes and no pulses. Then hold high 8+ cycles -> o_rise[1] after 10 edges from the last rising step.
- Drive i_bouncy[2]=1 and i_bouncy[3]=1 at different times:
  - Each channel rises exactly 10 edges after its own step.
  - Channel 0/1 outputs are unaffected.
- Raise i_bouncy[0], release it 20 cycles after o_rise -> o_fall[0] 10 edges after release and no o_held[0]. Re-press -> hold count restarts from 0.
- Assert i_rst for 1 cycle while o_debounced[2]=1 and mid-count on channel 3:
  - All outputs read 0 the next cycle with no o_fall.
  - With inputs still high, o_rise[2] and o_rise[3] follow 10 edges after reset deasserts.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: a bank of independent debounce filters for buttons and switches.
// Each channel synchronises its raw pin and accepts a new level only after
// DEBOUNCE_LIMIT consecutive disagreeing cycles. It then emits registered
// rise/fall pulses and a one-shot long-press (held) pulse.

module debounce_ch #(
    parameter int DEBOUNCE_LIMIT = 20,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_LIMIT     = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_bouncy,
    output logic o_debounced,
    output logic o_rise,
    output logic o_fall,
    output logic o_held
);
    localparam int DW = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam int HW = (HOLD_LIMIT > 2) ? $clog2(HOLD_LIMIT) : 1;
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_LIMIT - 1);
    localparam logic [HW-1:0] HMAX = HW'(HOLD_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0]          cnt_q, cnt_d;
    logic [HW-1:0]          hold_q, hold_d, hold_inc;
    logic                   state_q, state_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   held_q, held_d;
    logic                   s;

    // Next-state: synchroniser shift, debounce accept, hold counting
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], i_bouncy};
        s        = sync_q[SYNC_STAGES-1];
        cnt_d    = cnt_q;
        state_d  = state_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        hold_d   = hold_q;
        held_d   = 1'b0;
        hold_inc = hold_q + HW'(1);

        // Any agreeing cycle restarts the count, so short glitches never land
        if (s == state_q) begin
            cnt_d = '0;
        end else if (cnt_q == DMAX) begin
            state_d = s;
            cnt_d   = '0;
            rise_d  = s;
            fall_d  = ~s;
        end else begin
            cnt_d = cnt_q + DW'(1);
        end

        // Hold counter runs only while high and saturates, giving one pulse per press.
        // A fall on the same edge wins over the held pulse.
        if (!state_q) begin
            hold_d = '0;
        end else if (hold_q != HMAX) begin
            hold_d = hold_inc;
            held_d = (hold_inc == HMAX) && !fall_d;
        end
    end

    // State registers with synchronous reset; reset never produces a pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            held_q  <= held_d;
        end
    end

    assign o_debounced = state_q;
    assign o_rise      = rise_q;
    assign o_fall      = fall_q;
    assign o_held      = held_q;
endmodule

module debounce_bank #(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = 20,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_LIMIT     = 1000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_bouncy,
    output logic [NUM_CH-1:0] o_debounced,
    output logic [NUM_CH-1:0] o_rise,
    output logic [NUM_CH-1:0] o_fall,
    output logic [NUM_CH-1:0] o_held
);
    // One fully independent filter per channel
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
            .SYNC_STAGES   (SYNC_STAGES),
            .HOLD_LIMIT    (HOLD_LIMIT)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_bouncy   (i_bouncy[n]),
            .o_debounced(o_debounced[n]),
            .o_rise     (o_rise[n]),
            .o_fall     (o_fall[n]),
            .o_held     (o_held[n])
        );
    end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed scenarios plus random bouncing, checked every
// cycle against a timestamp-based model of the filter.

module tb_debounce_bank;
    localparam int NC = 4;
    localparam int DL = 8;
    localparam int SS = 2;
    localparam int HL = 32;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic [NC-1:0] i_bouncy = '0;
    logic [NC-1:0] o_debounced, o_rise, o_fall, o_held;

    debounce_bank #(
        .NUM_CH(NC), .DEBOUNCE_LIMIT(DL), .SYNC_STAGES(SS), .HOLD_LIMIT(HL)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_bouncy   (i_bouncy),
        .o_debounced(o_debounced),
        .o_rise     (o_rise),
        .o_fall     (o_fall),
        .o_held     (o_held)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_err    = 0;
    int edge_n   = 0;

    // Model: input seen by the filter lags the pin by SS edges; a new level is
    // accepted once it has disagreed for DL edges since the last agreement.
    bit            pipe[NC][$];
    bit            m_state[NC];
    int            last_agree[NC];
    int            rise_t[NC];
    logic [NC-1:0] e_deb, e_rise, e_fall, e_held;

    // Observations of the DUT for directed latency/count checks
    int obs_rise_edge[NC];
    int obs_fall_edge[NC];
    int n_held[NC];
    int n_pulse_any;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset(input int ch);
        pipe[ch].delete();
        for (int k = 0; k < SS; k++) pipe[ch].push_back(1'b0);
        m_state[ch]    = 1'b0;
        last_agree[ch] = edge_n;
        rise_t[ch]     = -100000;
    endtask

    task automatic tick();
        bit s;
        @(posedge i_clk);
        edge_n++;
        e_rise = '0;
        e_fall = '0;
        e_held = '0;
        for (int ch = 0; ch < NC; ch++) begin
            if (i_rst) begin
                model_reset(ch);
            end else begin
                s = pipe[ch].pop_front();
                pipe[ch].push_back(i_bouncy[ch]);
                if (s == m_state[ch]) begin
                    last_agree[ch] = edge_n;
                end else if (edge_n - last_agree[ch] >= DL) begin
                    m_state[ch]    = s;
                    last_agree[ch] = edge_n;
                    if (s) begin
                        e_rise[ch] = 1'b1;
                        rise_t[ch] = edge_n;
                    end else begin
                        e_fall[ch] = 1'b1;
                    end
                end
                e_held[ch] = m_state[ch] && (edge_n == rise_t[ch] + HL - 1);
            end
            e_deb[ch] = m_state[ch];
        end
        @(negedge i_clk);
        chk("debounced", int'(o_debounced), int'(e_deb));
        chk("rise", int'(o_rise), int'(e_rise));
        chk("fall", int'(o_fall), int'(e_fall));
        chk("held", int'(o_held), int'(e_held));
        for (int ch = 0; ch < NC; ch++) begin
            if (o_rise[ch]) obs_rise_edge[ch] = edge_n;
            if (o_fall[ch]) obs_fall_edge[ch] = edge_n;
            if (o_held[ch]) n_held[ch]++;
        end
        if ((o_rise | o_fall | o_held) != '0) n_pulse_any++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_obs();
        for (int ch = 0; ch < NC; ch++) begin
            obs_rise_edge[ch] = -1;
            obs_fall_edge[ch] = -1;
            n_held[ch]        = 0;
        end
        n_pulse_any = 0;
    endtask

    int            step_e, step3_e, rel_e;
    bit            tgt[NC];
    int            bnc[NC];
    logic [NC-1:0] nxt;

    initial begin
        for (int ch = 0; ch < NC; ch++) model_reset(ch);
        clear_obs();

        // Reset and idle
        @(negedge i_clk);
        i_rst = 1'b1;
        run(2);
        i_rst = 1'b0;
        chk("reset_outs", int'({o_debounced, o_rise, o_fall, o_held}), 0);
        run(50);
        chk("idle_pulses", n_pulse_any, 0);

        // Clean step on ch0: rise latency and a single held pulse
        clear_obs();
        step_e      = edge_n;
        i_bouncy[0] = 1'b1;
        run(60);
        chk("ch0_rise_lat", obs_rise_edge[0] - step_e, SS + DL);
        chk("ch0_held_cnt", n_held[0], 1);
        i_bouncy[0] = 1'b0;
        run(20);

        // Glitches on ch1 shorter than the limit are rejected
        clear_obs();
        i_bouncy[1] = 1'b1; run(7);
        i_bouncy[1] = 1'b0; run(1);
        i_bouncy[1] = 1'b1; run(7);
        chk("ch1_glitch", int'(o_debounced[1]), 0);
        chk("ch1_glitch_pulses", n_pulse_any, 0);
        run(20);
        chk("ch1_rise_lat", obs_rise_edge[1] - (edge_n - 27), SS + DL);
        i_bouncy[1] = 1'b0;
        run(20);

        // ch0: release 20 cycles after rise, no held; then re-press
        clear_obs();
        i_bouncy[0] = 1'b1;
        run(SS + DL + 20);
        rel_e       = edge_n;
        i_bouncy[0] = 1'b0;
        run(20);
        chk("ch0_fall_lat", obs_fall_edge[0] - rel_e, SS + DL);
        chk("ch0_no_held", n_held[0], 0);
        clear_obs();
        step_e      = edge_n;
        i_bouncy[0] = 1'b1;
        run(50);
        chk("ch0_held_restart", n_held[0], 1);
        i_bouncy[0] = 1'b0;
        run(20);

        // ch2 and ch3 stepped at different times; reset while ch3 mid-count
        clear_obs();
        step_e      = edge_n;
        i_bouncy[2] = 1'b1;
        run(15);
        step3_e     = edge_n;
        i_bouncy[3] = 1'b1;
        run(5);
        chk("ch2_rise_lat", obs_rise_edge[2] - step_e, SS + DL);
        chk("ch01_quiet", int'({o_debounced[1:0], o_rise[1:0]}), 0);
        i_rst = 1'b1;
        run(1);
        i_rst = 1'b0;
        chk("rst_fall", int'(o_fall), 0);
        clear_obs();
        step_e = edge_n;
        run(20);
        chk("ch2_rise_after_rst", obs_rise_edge[2] - step_e, SS + DL);
        chk("ch3_rise_after_rst", obs_rise_edge[3] - step_e, SS + DL);
        chk("ch3_not_early", int'(step3_e < step_e), 1);

        // Random bouncing with occasional resets
        for (int ch = 0; ch < NC; ch++) begin
            tgt[ch] = i_bouncy[ch];
            bnc[ch] = 0;
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int ch = 0; ch < NC; ch++) begin
                if ($urandom_range(0, 149) == 0) begin
                    tgt[ch] = ~tgt[ch];
                    bnc[ch] = $urandom_range(0, 14);
                end
                if (bnc[ch] > 0) begin
                    bnc[ch]--;
                    nxt[ch] = 1'($urandom_range(0, 1));
                end else begin
                    nxt[ch] = tgt[ch];
                end
            end
            i_bouncy = nxt;
            i_rst    = ($urandom_range(0, 999) == 0);
            tick();
        end
        i_rst = 1'b0;
        run(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
